// File: rtl/rtc_bus_sequencer.sv
// ---------------------------------------------------------------------------
// rtc_bus_sequencer
//
// Bus-timing engine for an RTC chip with a multiplexed 8-bit address/data bus.
// It turns one request (address, direction, write data) into a two-phase bus
// transaction: an address phase (A/D low) followed by a data phase (A/D high).
// Each phase has three parts: setup, strobe, hold. A recovery period with chip
// select deasserted follows before the engine goes idle again.
//
// Ports
//   clk_i      system clock
//   reset_i    synchronous active-high reset
//   start_i    request strobe, accepted only while idle
//   wr_nrd_i   1 = write, 0 = read
//   addr_i     RTC register address
//   wdata_i    write data
//   rdata_o    last completed read data
//   busy_o     high in every non-idle state
//   done_o     one-cycle pulse in the first idle cycle after a transaction
//   bus_o      value driven onto the AD bus
//   bus_oe_o   1 = FPGA drives the AD bus
//   bus_i      sampled AD bus
//   ad_o       A/D select: 0 = address, 1 = data
//   cs_o       chip select, active low
//   rd_o       read strobe, active low
//   wr_o       write strobe, active low
//
// All outputs come straight from flops. They are decoded from the *next*
// state, so each output flop changes on the same edge as the state register
// and the pins always match the state of the current cycle.
// ---------------------------------------------------------------------------
module rtc_bus_sequencer #(
    parameter int T_SU  = 2,
    parameter int T_PW  = 4,
    parameter int T_HD  = 2,
    parameter int T_REC = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       wr_nrd_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] rdata_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] bus_o,
    output logic       bus_oe_o,
    input  logic [7:0] bus_i,
    output logic       ad_o,
    output logic       cs_o,
    output logic       rd_o,
    output logic       wr_o
);

    typedef enum logic [2:0] {
        IDLE,
        A_SU,
        A_PW,
        A_HD,
        D_SU,
        D_PW,
        D_HD,
        REC
    } state_t;

    localparam int CW = 8;  // dwell counter width; every timing parameter is below 2**CW

    // Fixed state order of a transaction.
    function automatic state_t succ(input state_t s);
        case (s)
            A_SU:    return A_PW;
            A_PW:    return A_HD;
            A_HD:    return D_SU;
            D_SU:    return D_PW;
            D_PW:    return D_HD;
            D_HD:    return REC;
            default: return IDLE;
        endcase
    endfunction

    // Counter load value on state entry: the state lasts load+1 cycles.
    function automatic logic [CW-1:0] dwell(input state_t s);
        case (s)
            A_SU, D_SU: return CW'(T_SU - 1);
            A_PW, D_PW: return CW'(T_PW - 1);
            A_HD, D_HD: return CW'(T_HD - 1);
            REC:        return CW'(T_REC - 1);
            default:    return '0;
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          is_wr_q, is_wr_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [7:0]    bus_q, bus_d;
    logic          bus_oe_q, bus_oe_d;
    logic          ad_q, ad_d;
    logic          cs_n_q, cs_n_d;
    logic          rd_n_q, rd_n_d;
    logic          wr_n_q, wr_n_d;

    logic addr_phase, data_phase;

    // Next-state, request latch and dwell counter.
    always_comb begin
        // NOTE: every signal gets a default before the case; a path that
        // skipped an assignment would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;

        if (state_q == IDLE) begin
            if (start_i) begin
                state_d = A_SU;
                cnt_d   = dwell(A_SU);
                addr_d  = addr_i;
                wdata_d = wdata_i;
                is_wr_d = wr_nrd_i;
            end
        end else if (cnt_q == '0) begin
            state_d = succ(state_q);
            cnt_d   = dwell(succ(state_q));
            // Capture read data on the edge that closes the last RD-low cycle.
            if (state_q == D_PW && !is_wr_q) begin
                rdata_d = bus_i;
            end
            if (state_q == REC) begin
                done_d = 1'b1;
            end
        end else begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Output decode from the next state so the output flops track the state flop.
    assign addr_phase = (state_d == A_SU) || (state_d == A_PW) || (state_d == A_HD);
    assign data_phase = (state_d == D_SU) || (state_d == D_PW) || (state_d == D_HD);

    always_comb begin
        busy_d   = (state_d != IDLE);
        bus_d    = bus_q;  // holds its last value while not driven
        bus_oe_d = 1'b0;
        ad_d     = 1'b1;
        cs_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;

        if (addr_phase) begin
            ad_d     = 1'b0;
            cs_n_d   = 1'b0;
            bus_oe_d = 1'b1;
            bus_d    = addr_d;
            wr_n_d   = (state_d != A_PW);  // address latch pulse for both directions
        end else if (data_phase) begin
            cs_n_d = 1'b0;
            if (is_wr_d) begin
                bus_oe_d = 1'b1;
                bus_d    = wdata_d;
                wr_n_d   = (state_d != D_PW);
            end else begin
                rd_n_d = (state_d != D_PW);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            is_wr_q  <= 1'b0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bus_q    <= '0;
            bus_oe_q <= 1'b0;
            ad_q     <= 1'b1;
            cs_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            is_wr_q  <= is_wr_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            bus_q    <= bus_d;
            bus_oe_q <= bus_oe_d;
            ad_q     <= ad_d;
            cs_n_q   <= cs_n_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
        end
    end

    assign rdata_o  = rdata_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign bus_o    = bus_q;
    assign bus_oe_o = bus_oe_q;
    assign ad_o     = ad_q;
    assign cs_o     = cs_n_q;
    assign rd_o     = rd_n_q;
    assign wr_o     = wr_n_q;

endmodule
